duck_flight_ctrl: RTL and testbench
===================================

DUCK_FLIGHT_CTRL -- requirements
Module: duck_flight_ctrl

Interface
REQ-001 Parameters SHALL be X_MIN, 0, left bound; X_MAX, 639, right bound; Y_MIN, 0, top bound; Y_MAX, 399, bottom bound.
REQ-002 Parameters SHALL be STEP, 2, flight px/frame per axis; FALL_STEP, 4, fall px/frame; TIMEOUT_FRAMES, 300, flight frames before escape; HIT_FRAMES, 30, freeze frames after hit.
REQ-003 Clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 frame_tick  in  1  one-cycle pulse per video frame; all motion and frame counting advance only on it.
REQ-006 launch  in  1  one-cycle pulse requesting a new duck.
REQ-007 launch_x  in  10  starting x; launch_dir  in  1  initial horizontal direction (1 = right).
REQ-008 shot_hit  in  1  one-cycle pulse from hit detection.
REQ-009 duck_x, duck_y  out  10 each  current duck position.
REQ-010 state  out  3  IDLE=0, FLYING=1, HIT=2, FALLING=3, ESCAPING=4, GONE=5.
REQ-011 flew_away  out  1  level; feeds the bird counter's rising-edge detector.
REQ-012 shot_down  out  1  one-cycle pulse on a registered hit; duck_active  out  1  high in FLYING, HIT, FALLING, ESCAPING.

Function
REQ-013 All outputs SHALL be registered or decoded from registered state only.
REQ-014 launch SHALL be accepted only in IDLE or GONE; otherwise ignored.
REQ-015 On acceptance: duck_x<=launch_x clamped to [X_MIN,X_MAX], duck_y<=Y_MAX, dx sign<=launch_dir, dy=up, frame_cnt<=0, escaped<=0, state<=FLYING on the next edge.
REQ-016 FLYING, per frame_tick: x,y each move STEP in their current direction; frame_cnt increments.
REQ-017 Bounce: if the move would pass X_MAX (or X_MIN), x SHALL be set to the bound and dx reversed that tick; same for y with Y_MIN/Y_MAX and dy.
REQ-018 Bound checks SHALL be evaluated before the add/subtract, so no unsigned wrap-around is ever visible on duck_x/duck_y.
REQ-019 FLYING: shot_hit in any cycle SHALL give state<=HIT, shot_down=1 for exactly that next cycle, position frozen.
REQ-020 FLYING: on the frame_tick where frame_cnt==TIMEOUT_FRAMES-1, state SHALL become ESCAPING.
REQ-021 If shot_hit and the timeout tick occur in the same cycle, HIT SHALL win.
REQ-022 HIT: position held; frame_cnt reset on entry; after HIT_FRAMES frame_ticks, state<=FALLING.
REQ-023 FALLING: y increases by FALL_STEP per tick, x held; if y > Y_MAX-FALL_STEP, y<=Y_MAX and state<=GONE with escaped=0.
REQ-024 ESCAPING: y decreases by STEP per tick, x held, shot_hit ignored; if y < Y_MIN+STEP, y<=Y_MIN and state<=GONE with escaped=1.
REQ-025 flew_away SHALL be 1 exactly when state==GONE and escaped==1, held until the next accepted launch or Reset.
REQ-026 shot_hit outside FLYING SHALL be ignored; frame_tick in IDLE/GONE SHALL change nothing.
REQ-027 A launch coincident with frame_tick in GONE SHALL take launch priority: no motion that cycle.

Reset
REQ-028 While Reset is high: state=IDLE, duck_x=X_MIN, duck_y=Y_MAX, frame_cnt=0, escaped=0, flew_away=0, shot_down=0, duck_active=0.
REQ-029 Reset SHALL override all inputs in any state, including mid-flight, mid-fall and GONE.

Verification
REQ-030 Launch launch_x=100, dir=1, 3 ticks, no hit -> (106,393), state=1.
REQ-031 Launch launch_x=637, dir=1, 1 tick -> duck_x=639 with dx reversed; next tick -> duck_x=637.
REQ-032 Launch, no hit, 300 ticks -> state=4; escape to y=0 -> state=5, flew_away=1 until the next launch.
REQ-033 shot_hit after 10 ticks -> shot_down high 1 cycle, state=2; 30 ticks -> 3; fall to y=399 -> 5, flew_away=0.
REQ-034 shot_hit on the same cycle as tick 300 -> state=2, never 4.
REQ-035 Reset asserted in FALLING -> next edge all outputs at REQ-028 values; launch in HIT ignored.

Source files
------------

// File: rtl/duck_flight_ctrl.sv
// rtl/duck_flight_ctrl.sv - duck position/state controller for a frame-stepped shooting game
//
// Purpose: launches a duck, bounces it inside the play field once per video
// frame, and then resolves the flight in one of two ways. If the duck is shot,
// it freezes, falls and is marked shot down. If the flight time runs out, it
// escapes off the top of the field.
//
// Ports:
//   Clk          system clock, all logic on the rising edge
//   Reset        synchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame; motion and frame counting step on it
//   launch       one-cycle request for a new duck (honoured in IDLE/GONE only)
//   launch_x     starting x position (clamped into the field)
//   launch_dir   initial horizontal direction, 1 = right
//   shot_hit     one-cycle pulse from hit detection (honoured in FLYING only)
//   duck_x/y     current duck position
//   state        IDLE=0 FLYING=1 HIT=2 FALLING=3 ESCAPING=4 GONE=5
//   flew_away    level, high while GONE after an escape
//   shot_down    one-cycle pulse on the cycle after a registered hit
//   duck_active  high in FLYING, HIT, FALLING and ESCAPING

module duck_flight_ctrl #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 639,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 399,
    parameter int STEP           = 2,
    parameter int FALL_STEP      = 4,
    parameter int TIMEOUT_FRAMES = 300,
    parameter int HIT_FRAMES     = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] launch_x,
    input  logic       launch_dir,
    input  logic       shot_hit,
    output logic [9:0] duck_x,
    output logic [9:0] duck_y,
    output logic [2:0] state,
    output logic       flew_away,
    output logic       shot_down,
    output logic       duck_active
);

    // One counter serves both the flight timeout and the hit freeze.
    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + HIT_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLYING   = 3'd1,
        S_HIT      = 3'd2,
        S_FALLING  = 3'd3,
        S_ESCAPING = 3'd4,
        S_GONE     = 3'd5
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;

    logic             dx_right;   // 1 = moving toward X_MAX
    logic             dy_down;    // 1 = moving toward Y_MAX
    logic             escaped;
    logic [CNT_W-1:0] frame_cnt;

    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             dx_nxt;
    logic             dy_nxt;
    logic             esc_nxt;
    logic             shot_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Position arithmetic is done in signed 32-bit so every bound check is made
    // on the current value before stepping; nothing can wrap on the 10-bit outputs.
    int               xi;
    int               yi;
    int               lxi;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        x_nxt     = duck_x;
        y_nxt     = duck_y;
        dx_nxt    = dx_right;
        dy_nxt    = dy_down;
        cnt_nxt   = frame_cnt;
        esc_nxt   = escaped;
        shot_nxt  = 1'b0;
        xi        = int'(duck_x);
        yi        = int'(duck_y);
        lxi       = int'(launch_x);

        case (cur_state)
            // A launch outranks a coincident frame_tick; ticks alone do nothing here.
            S_IDLE, S_GONE: begin
                if (launch) begin
                    nxt_state = S_FLYING;
                    if (lxi > X_MAX) begin
                        x_nxt = 10'(X_MAX);
                    end else if (lxi < X_MIN) begin
                        x_nxt = 10'(X_MIN);
                    end else begin
                        x_nxt = launch_x;
                    end
                    y_nxt   = 10'(Y_MAX);
                    dx_nxt  = launch_dir;
                    dy_nxt  = 1'b0;
                    cnt_nxt = '0;
                    esc_nxt = 1'b0;
                end
            end

            S_FLYING: begin
                // A hit freezes the duck immediately, even on a timeout tick.
                if (shot_hit) begin
                    nxt_state = S_HIT;
                    cnt_nxt   = '0;
                    shot_nxt  = 1'b1;
                end else if (frame_tick) begin
                    // Reaching a bound counts as hitting it: snap there and turn around.
                    if (dx_right) begin
                        if (xi >= X_MAX - STEP) begin
                            x_nxt  = 10'(X_MAX);
                            dx_nxt = 1'b0;
                        end else begin
                            x_nxt = 10'(xi + STEP);
                        end
                    end else begin
                        if (xi <= X_MIN + STEP) begin
                            x_nxt  = 10'(X_MIN);
                            dx_nxt = 1'b1;
                        end else begin
                            x_nxt = 10'(xi - STEP);
                        end
                    end

                    if (dy_down) begin
                        if (yi >= Y_MAX - STEP) begin
                            y_nxt  = 10'(Y_MAX);
                            dy_nxt = 1'b0;
                        end else begin
                            y_nxt = 10'(yi + STEP);
                        end
                    end else begin
                        if (yi <= Y_MIN + STEP) begin
                            y_nxt  = 10'(Y_MIN);
                            dy_nxt = 1'b1;
                        end else begin
                            y_nxt = 10'(yi - STEP);
                        end
                    end

                    if (frame_cnt == CNT_W'(TIMEOUT_FRAMES - 1)) begin
                        nxt_state = S_ESCAPING;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end

            S_HIT: begin
                if (frame_tick) begin
                    if (frame_cnt == CNT_W'(HIT_FRAMES - 1)) begin
                        nxt_state = S_FALLING;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end

            S_FALLING: begin
                if (frame_tick) begin
                    if (yi > Y_MAX - FALL_STEP) begin
                        y_nxt     = 10'(Y_MAX);
                        nxt_state = S_GONE;
                        esc_nxt   = 1'b0;
                    end else begin
                        y_nxt = 10'(yi + FALL_STEP);
                    end
                end
            end

            // Escaping ducks cannot be shot; shot_hit is not looked at here.
            S_ESCAPING: begin
                if (frame_tick) begin
                    if (yi < Y_MIN + STEP) begin
                        y_nxt     = 10'(Y_MIN);
                        nxt_state = S_GONE;
                        esc_nxt   = 1'b1;
                    end else begin
                        y_nxt = 10'(yi - STEP);
                    end
                end
            end

            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            duck_x    <= 10'(X_MIN);
            duck_y    <= 10'(Y_MAX);
            dx_right  <= 1'b1;
            dy_down   <= 1'b0;
            frame_cnt <= '0;
            escaped   <= 1'b0;
            shot_down <= 1'b0;
        end else begin
            duck_x    <= x_nxt;
            duck_y    <= y_nxt;
            dx_right  <= dx_nxt;
            dy_down   <= dy_nxt;
            frame_cnt <= cnt_nxt;
            escaped   <= esc_nxt;
            shot_down <= shot_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        state       = cur_state;
        flew_away   = (cur_state == S_GONE) && escaped;
        duck_active = (cur_state == S_FLYING)  || (cur_state == S_HIT) ||
                      (cur_state == S_FALLING) || (cur_state == S_ESCAPING);
    end

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// tb/tb_duck_flight_ctrl.sv - self-checking bench for duck_flight_ctrl

module tb_duck_flight_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch = 1'b0;
    logic [9:0] launch_x = '0;
    logic       launch_dir = 1'b0;
    logic       shot_hit = 1'b0;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic [2:0] state;
    logic       flew_away;
    logic       shot_down;
    logic       duck_active;

    int n_cmp = 0;
    int n_bad = 0;

    duck_flight_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .launch      (launch),
        .launch_x    (launch_x),
        .launch_dir  (launch_dir),
        .shot_hit    (shot_hit),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
        .state       (state),
        .flew_away   (flew_away),
        .shot_down   (shot_down),
        .duck_active (duck_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string name;
        int    x;
        int    y;
        int    st;
        bit    fa;
        bit    sd;
        bit    act;
    } exp_t;

    typedef struct {
        int lx;
        bit dir;
        int ticks;
        int ex;
        int ey;
    } vec_t;

    exp_t sb[$];
    vec_t vt[11];

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic do_launch(input int lx, input bit dir);
        launch     = 1'b1;
        launch_x   = 10'(lx);
        launch_dir = dir;
        cyc();
        launch     = 1'b0;
    endtask

    task automatic push_exp(input string nm, input int x, input int y, input int st,
                            input bit fa, input bit sd, input bit act);
        exp_t e;
        e.name = nm;
        e.x    = x;
        e.y    = y;
        e.st   = st;
        e.fa   = fa;
        e.sd   = sd;
        e.act  = act;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: output sampled with nothing expected");
        end else begin
            e = sb.pop_front();
            if (duck_x !== 10'(e.x) || duck_y !== 10'(e.y) || state !== 3'(e.st) ||
                flew_away !== e.fa || shot_down !== e.sd || duck_active !== e.act) begin
                n_bad++;
                $display("FAIL %s: got x=%0d y=%0d st=%0d fa=%0b sd=%0b act=%0b, want x=%0d y=%0d st=%0d fa=%0b sd=%0b act=%0b",
                         e.name, duck_x, duck_y, state, flew_away, shot_down, duck_active,
                         e.x, e.y, e.st, e.fa, e.sd, e.act);
            end
        end
    endtask

    initial begin
        // {launch_x, dir, ticks, expected x, expected y}; all expected FLYING.
        vt[0]  = '{100,  1'b1, 3,   106, 393};
        vt[1]  = '{637,  1'b1, 1,   639, 397};
        vt[2]  = '{637,  1'b1, 2,   637, 395};
        vt[3]  = '{1,    1'b0, 1,   0,   397};
        vt[4]  = '{1,    1'b0, 2,   2,   395};
        vt[5]  = '{700,  1'b0, 0,   639, 399};
        vt[6]  = '{1023, 1'b1, 1,   639, 397};
        vt[7]  = '{100,  1'b1, 200, 500, 0};
        vt[8]  = '{100,  1'b1, 201, 502, 2};
        vt[9]  = '{0,    1'b0, 1,   0,   397};
        vt[10] = '{638,  1'b1, 1,   639, 397};

        // Reset values, then stray hit/tick in IDLE change nothing.
        push_exp("reset_state", 0, 399, 0, 0, 0, 0);
        do_reset();
        pop_cmp();
        push_exp("idle_ignores_hit_tick", 0, 399, 0, 0, 0, 0);
        shot_hit   = 1'b1;
        frame_tick = 1'b1;
        cyc();
        shot_hit   = 1'b0;
        frame_tick = 1'b0;
        pop_cmp();

        // Flight and bounce table.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            push_exp($sformatf("flight_vec%0d", i), vt[i].ex, vt[i].ey, 1, 0, 0, 1);
            do_launch(vt[i].lx, vt[i].dir);
            ticks(vt[i].ticks);
            pop_cmp();
        end

        // Timeout, escape, GONE hold, shot ignored while escaping, relaunch priority.
        do_reset();
        do_launch(100, 1'b1);
        push_exp("flying_before_timeout", 581, 198, 1, 0, 0, 1);
        ticks(299);
        pop_cmp();
        push_exp("timeout_escaping", 579, 200, 4, 0, 0, 1);
        ticks(1);
        pop_cmp();
        ticks(50);
        push_exp("escape_ignores_hit", 579, 100, 4, 0, 0, 1);
        shot_hit = 1'b1;
        cyc();
        shot_hit = 1'b0;
        pop_cmp();
        push_exp("escape_at_top", 579, 0, 4, 0, 0, 1);
        ticks(50);
        pop_cmp();
        push_exp("escape_gone", 579, 0, 5, 1, 0, 0);
        ticks(1);
        pop_cmp();
        push_exp("gone_holds", 579, 0, 5, 1, 0, 0);
        ticks(3);
        pop_cmp();
        push_exp("gone_launch_beats_tick", 300, 399, 1, 0, 0, 1);
        frame_tick = 1'b1;
        do_launch(300, 1'b0);
        frame_tick = 1'b0;
        pop_cmp();

        // Hit, freeze, launch ignored in HIT, fall to the ground.
        do_reset();
        do_launch(100, 1'b1);
        ticks(10);
        push_exp("hit_shot_down", 120, 379, 2, 0, 1, 1);
        shot_hit = 1'b1;
        cyc();
        shot_hit = 1'b0;
        pop_cmp();
        push_exp("hit_launch_ignored", 120, 379, 2, 0, 0, 1);
        do_launch(5, 1'b0);
        pop_cmp();
        push_exp("hit_hold_29", 120, 379, 2, 0, 0, 1);
        ticks(29);
        pop_cmp();
        push_exp("hit_to_falling", 120, 379, 3, 0, 0, 1);
        ticks(1);
        pop_cmp();
        push_exp("falling_at_ground", 120, 399, 3, 0, 0, 1);
        ticks(5);
        pop_cmp();
        push_exp("fall_gone", 120, 399, 5, 0, 0, 0);
        ticks(1);
        pop_cmp();

        // Reset (with a coincident launch) in the middle of a fall.
        do_reset();
        do_launch(100, 1'b1);
        ticks(10);
        shot_hit = 1'b1;
        cyc();
        shot_hit = 1'b0;
        ticks(30);
        push_exp("mid_fall", 120, 387, 3, 0, 0, 1);
        ticks(2);
        pop_cmp();
        push_exp("reset_in_falling", 0, 399, 0, 0, 0, 0);
        Reset  = 1'b1;
        launch = 1'b1;
        cyc();
        Reset  = 1'b0;
        launch = 1'b0;
        pop_cmp();

        // Hit on the timeout tick wins over escape.
        do_reset();
        do_launch(100, 1'b1);
        ticks(299);
        push_exp("hit_beats_timeout", 581, 198, 2, 0, 1, 1);
        frame_tick = 1'b1;
        shot_hit   = 1'b1;
        cyc();
        frame_tick = 1'b0;
        shot_hit   = 1'b0;
        pop_cmp();
        push_exp("hit_never_escapes", 581, 198, 2, 0, 0, 1);
        ticks(5);
        pop_cmp();

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d expected entries never compared", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
